imem_loader: RTL and testbench

Boot-time program loader that fills the instruction memory from a byte stream. It parses a little-endian 32-bit word count followed by that many little-endian 32-bit instruction words, and writes each word to consecutive word-aligned addresses on the memory write port. It holds the CPU in reset until the load completes. It sits between the host byte link (UART receiver or testbench) and the write side of the instruction memory that the fetch stage reads.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_le_word_packer.sv | 35 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_WIDTH     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_le_word_packer.sv
// rtl/imem_loader_le_word_packer.sv - little-endian byte-to-word packer
// word presents the assembled value including the byte on byte_in, so it is complete while word_full is high.
module le_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [LANE_WIDTH-1:0] lane;
  logic [31:0]           shift;

  // Bytes enter at the top, so the first byte of four ends up in [7:0].
  assign word      = {byte_in, shift[31:8]};
  assign word_full = strobe && (lane == LANE_WIDTH'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      shift <= '0;
    end else if (clear) begin
      lane  <= '0;
      shift <= '0;
    end else if (strobe) begin
      lane  <= lane + 1'b1;
      shift <= word;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader filling instruction memory from a little-endian byte stream
// Holds the CPU in reset until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

  state_t                state;
  state_t                state_next;
  logic [31:0]           count;
  logic [31:0]           word_q;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           packed_word;
  logic                  word_full;
  logic                  accept;
  logic                  start_load;
  logic                  last_word;

  assign accept     = byte_valid && byte_ready;
  assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign last_word  = (32'(word_idx) == (count - 32'd1));

  le_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_load),
    .strobe    (accept),
    .byte_in   (byte_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_next = LEN;
      end
      LEN: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        // Oversize counts are rejected here, which is what keeps word_idx from wrapping.
        if (word_full) begin
          if (packed_word == 32'd0)
            state_next = DONE;
          else if ({1'b0, packed_word} > CAPACITY)
            state_next = ERROR;
          else
            state_next = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (word_full) state_next = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_next = LEN;
      end
      ERROR: begin
        err = 1'b1;
        if (start) state_next = LEN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      word_q   <= '0;
      word_idx <= '0;
    end else begin
      if (start_load) begin
        count    <= '0;
        word_idx <= '0;
      end
      if ((state == LEN) && word_full)
        count <= packed_word;
      if ((state == DATA) && word_full)
        word_q <= packed_word;
      if ((state == WRITE) && !last_word)
        word_idx <= word_idx + 1'b1;
    end
  end

  assign mem_addr  = 32'({word_idx, 2'b00});
  assign mem_wdata = word_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int          checks   = 0;
  int          failures = 0;
  int          acc_cnt  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stim[$];

  imem_loader #(.ADDR_WIDTH(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so valid/ready are stable at the negedge before the transfer edge.
  always @(negedge clk) begin
    if (rst_n && byte_valid && byte_ready) acc_cnt++;
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    acc_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_stim(input int gap_pct);
    int   idx    = 0;
    int   budget = stim.size() * 40 + 100;
    logic acc;
    while (idx < stim.size() && budget > 0) begin
      byte_valid = ($urandom_range(0, 99) >= gap_pct);
      byte_data  = byte_valid ? stim[idx] : 8'($urandom);
      @(negedge clk);
      acc = byte_valid && byte_ready;
      tick();
      if (acc) idx++;
      budget--;
    end
    byte_valid = 1'b0;
    checks++;
    if (idx != stim.size()) begin
      failures++;
      $display("FAIL send_stim_timeout: consumed %0d bytes, required %0d", idx, stim.size());
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
    if (mem_we !== 1'b0)     begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    if (mem_addr !== 32'h0)  begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    if (err !== 1'b0)        begin failures++; $display("FAIL reset_err: got %b want 0", err); end
    if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end

    // Abort a load in the middle of the first data word.
    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05};
    send_stim(0);
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (byte_ready !== 1'b0) begin failures++; $display("FAIL midload_byte_ready: got %b want 0", byte_ready); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL midload_busy: got %b want 0", busy); end
    if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL midload_cpu_hold: got %b want 1", cpu_hold); end
    if (mem_addr !== 32'h0)  begin failures++; $display("FAIL midload_mem_addr: got %h want 0", mem_addr); end
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks += 2;
    if (wr_addr.size() != 0) begin failures++; $display("FAIL midload_no_write: got %0d writes want 0", wr_addr.size()); end
    if (done !== 1'b0)       begin failures++; $display("FAIL midload_idle_done: got %b want 0", done); end

    // A fresh start after the abort must load cleanly.
    clear_log();
    pulse_start();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    send_stim(0);
    tick();
    checks += 3;
    if (wr_addr.size() != 1) begin failures++; $display("FAIL reload_write_count: got %0d want 1", wr_addr.size()); end
    else if (wr_data[0] !== 32'h12345678 || wr_addr[0] !== 32'h0) begin
      failures++; $display("FAIL reload_write: got %h@%h want 12345678@0", wr_data[0], wr_addr[0]);
    end
    if (done !== 1'b1) begin failures++; $display("FAIL reload_done: got %b want 1", done); end
  endtask

  task automatic test_basic_load();
    clear_log();
    pulse_start();
    checks += 3;
    if (byte_ready !== 1'b1) begin failures++; $display("FAIL start_byte_ready: got %b want 1", byte_ready); end
    if (busy !== 1'b1)       begin failures++; $display("FAIL start_busy: got %b want 1", busy); end
    if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL start_cpu_hold: got %b want 1", cpu_hold); end
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_stim(0);
    checks += 4;
    if (mem_we !== 1'b1)            begin failures++; $display("FAIL basic_we_latency: got %b want 1", mem_we); end
    if (mem_addr !== 32'h4)         begin failures++; $display("FAIL basic_last_addr: got %h want 4", mem_addr); end
    if (mem_wdata !== 32'h0000006F) begin failures++; $display("FAIL basic_last_data: got %h want 0000006f", mem_wdata); end
    if (byte_ready !== 1'b0)        begin failures++; $display("FAIL basic_write_ready: got %b want 0", byte_ready); end
    tick();
    checks += 4;
    if (done !== 1'b1)     begin failures++; $display("FAIL basic_done: got %b want 1", done); end
    if (cpu_hold !== 1'b0) begin failures++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL basic_busy: got %b want 0", busy); end
    if (mem_we !== 1'b0)   begin failures++; $display("FAIL basic_we_after: got %b want 0", mem_we); end
    checks += 2;
    if (wr_addr.size() != 2) begin
      failures++; $display("FAIL basic_write_count: got %0d want 2", wr_addr.size());
    end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00100513 ||
                 wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0000006F) begin
      failures++;
      $display("FAIL basic_writes: got %h@%h %h@%h want 00100513@0 0000006f@4",
               wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
    end
    if (acc_cnt != 12) begin failures++; $display("FAIL basic_accepted: got %0d want 12", acc_cnt); end
  endtask

  task automatic test_backpressure();
    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_stim(50);
    tick();
    checks += 3;
    if (acc_cnt != 12) begin failures++; $display("FAIL bp_accepted: got %0d want 12", acc_cnt); end
    if (wr_addr.size() != 2) begin
      failures++; $display("FAIL bp_write_count: got %0d want 2", wr_addr.size());
    end else if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00100513 ||
                 wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0000006F) begin
      failures++;
      $display("FAIL bp_writes: got %h@%h %h@%h want 00100513@0 0000006f@4",
               wr_data[0], wr_addr[0], wr_data[1], wr_addr[1]);
    end
    if (done !== 1'b1) begin failures++; $display("FAIL bp_done: got %b want 1", done); end
  endtask

  task automatic test_zero_count();
    clear_log();
    pulse_start();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stim(0);
    checks += 3;
    if (done !== 1'b1)     begin failures++; $display("FAIL zero_done: got %b want 1", done); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL zero_busy: got %b want 0", busy); end
    if (cpu_hold !== 1'b0) begin failures++; $display("FAIL zero_cpu_hold: got %b want 0", cpu_hold); end
    byte_valid = 1'b1;
    byte_data  = 8'hAA;
    repeat (5) tick();
    byte_valid = 1'b0;
    checks += 2;
    if (acc_cnt != 4)        begin failures++; $display("FAIL zero_trailing_accepted: got %0d want 4", acc_cnt); end
    if (wr_addr.size() != 0) begin failures++; $display("FAIL zero_no_write: got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start();
    stim = '{8'h01, 8'h10, 8'h00, 8'h00};
    send_stim(0);
    checks += 4;
    if (err !== 1'b1)      begin failures++; $display("FAIL over_err: got %b want 1", err); end
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL over_cpu_hold: got %b want 1", cpu_hold); end
    if (done !== 1'b0)     begin failures++; $display("FAIL over_done: got %b want 0", done); end
    if (busy !== 1'b0)     begin failures++; $display("FAIL over_busy: got %b want 0", busy); end
    repeat (3) tick();
    checks++;
    if (wr_addr.size() != 0) begin failures++; $display("FAIL over_no_write: got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_full_capacity();
    logic [31:0] w;
    int          bad = 0;
    clear_log();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL cap_start_from_error: got busy %b want 1", busy); end
    stim = '{8'h00, 8'h10, 8'h00, 8'h00};
    for (int i = 0; i < 4096; i++) begin
      w = 32'hC0DE0000 | 32'(i);
      stim.push_back(w[7:0]);
      stim.push_back(w[15:8]);
      stim.push_back(w[23:16]);
      stim.push_back(w[31:24]);
    end
    send_stim(0);
    checks += 2;
    if (mem_we !== 1'b1)       begin failures++; $display("FAIL cap_last_we: got %b want 1", mem_we); end
    if (mem_addr !== 32'h3FFC) begin failures++; $display("FAIL cap_last_addr: got %h want 3ffc", mem_addr); end
    tick();
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL cap_done: got %b want 1", done); end
    if (wr_addr.size() != 4096) begin
      failures++; $display("FAIL cap_write_count: got %0d want 4096", wr_addr.size());
    end else begin
      for (int i = 0; i < 4096; i++)
        if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== (32'hC0DE0000 | 32'(i))) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL cap_writes: got %0d bad writes want 0", bad); end
    end
  endtask

  task automatic test_restart();
    clear_log();
    pulse_start();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    send_stim(0);
    pulse_start();
    pulse_start();
    checks++;
    if (byte_ready !== 1'b1) begin failures++; $display("FAIL busy_start_state: got ready %b want 1", byte_ready); end
    stim = '{8'h6F, 8'h00, 8'h00, 8'h00};
    send_stim(0);
    tick();
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL busy_start_done: got %b want 1", done); end
    if (wr_addr.size() != 2) begin
      failures++; $display("FAIL busy_start_writes: got %0d want 2", wr_addr.size());
    end else if (wr_data[1] !== 32'h0000006F || wr_addr[1] !== 32'h4) begin
      failures++; $display("FAIL busy_start_second: got %h@%h want 0000006f@4", wr_data[1], wr_addr[1]);
    end

    clear_log();
    pulse_start();
    checks += 3;
    if (cpu_hold !== 1'b1)   begin failures++; $display("FAIL restart_cpu_hold: got %b want 1", cpu_hold); end
    if (byte_ready !== 1'b1) begin failures++; $display("FAIL restart_byte_ready: got %b want 1", byte_ready); end
    if (done !== 1'b0)       begin failures++; $display("FAIL restart_done: got %b want 0", done); end
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_stim(0);
    checks += 3;
    if (mem_we !== 1'b1)            begin failures++; $display("FAIL restart_we: got %b want 1", mem_we); end
    if (mem_addr !== 32'h0)         begin failures++; $display("FAIL restart_addr: got %h want 0", mem_addr); end
    if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL restart_data: got %h want deadbeef", mem_wdata); end
    tick();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL restart_final_done: got %b want 1", done); end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_zero_count();
    test_oversize();
    test_full_capacity();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
